motor_dir_sequencer: RTL and testbench

Single-motor command sequencer that drives the motor direction demux. It accepts direction/duty commands from the line-follower control logic over a valid/ready handshake and arms only after the start key is pressed. It inserts coast dead-time on every forward/reverse reversal, generates the PWM carrier, and forces coast if commands stop arriving. Outputs m1a1/m1b1/pwm_out connect directly to the demux inputs of the same names.

---
 rtl/motor_pkg.sv | 30 +++
 rtl/motor_dir_sequencer_pwm_gen.sv | 47 ++++
 rtl/motor_dir_sequencer.sv | 177 +++++++++++++++++
 tb/tb_motor_dir_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared direction codes, FSM state encoding and command payload for the motor sequencer.
package motor_pkg;

   localparam int unsigned PWM_W = 8;

   localparam logic [1:0] DIR_COAST = 2'b00;
   localparam logic [1:0] DIR_REV   = 2'b01;
   localparam logic [1:0] DIR_FWD   = 2'b10;
   localparam logic [1:0] DIR_BRAKE = 2'b11;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_RUN      = 2'd1,
      ST_DEAD     = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0]       dir;
      logic [PWM_W-1:0] duty;
   } motor_cmd_t;

   function automatic logic is_drive(input logic [1:0] d);
      return (d == DIR_REV) || (d == DIR_FWD);
   endfunction

   function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] nxt);
      return is_drive(cur) && is_drive(nxt) && (cur != nxt);
   endfunction

endpackage

// File: rtl/motor_dir_sequencer_pwm_gen.sv
// PWM carrier: prescaler, 8-bit period counter, period-boundary strobe and duty compare.
module pwm_gen
   import motor_pkg::*;
#(
   parameter int unsigned PWM_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [PWM_W-1:0] duty_eff,
   output logic             pwm_out,
   output logic             wrap
);

   localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   logic [PRE_W-1:0] pre_q, pre_nx;
   logic [PWM_W-1:0] cnt_q, cnt_nx;

   always_comb begin
      pre_nx = pre_q;
      cnt_nx = cnt_q;
      if (pre_q == PRE_W'(PWM_DIV - 1)) begin
         pre_nx = '0;
         cnt_nx = cnt_q + 1'b1;
      end else begin
         pre_nx = pre_q + 1'b1;
      end
   end

   // wrap is high during the last prescale cycle of count 255, so a duty loaded
   // on it governs the whole next period including slot 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q   <= '0;
         cnt_q   <= '0;
         wrap    <= 1'b0;
         pwm_out <= 1'b0;
      end else begin
         pre_q   <= pre_nx;
         cnt_q   <= cnt_nx;
         wrap    <= (pre_nx == PRE_W'(PWM_DIV - 1)) && (cnt_nx == '1);
         pwm_out <= en && (cnt_q < duty_eff);
      end
   end

endmodule

// File: rtl/motor_dir_sequencer.sv
// Motor direction sequencer: arming, command handshake, reversal dead-time and watchdog.
// Optional MOTOR_RAMP_EN: duty_eff ramps by one step per PWM period toward the target.
module motor_dir_sequencer
   import motor_pkg::*;
#(
   parameter int unsigned PWM_DIV     = 4,
   parameter int unsigned DEAD_CYCLES = 500,
   parameter int unsigned WDOG_CYCLES = 5000000
) (
   input  logic             clk_50M,
   input  logic             rst_n,
   input  logic             key,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_dir,
   input  logic [PWM_W-1:0] cmd_duty,
   output logic             m1a1,
   output logic             m1b1,
   output logic             pwm_out,
   output logic             armed,
   output logic             wdog_timeout
);

   localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);
   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

   state_t           state_q, state_nx;
   logic [1:0]       dir_q, dir_nx;
   motor_cmd_t       pend_q, pend_nx;
   logic [PWM_W-1:0] target_q, target_nx;
   logic [PWM_W-1:0] duty_eff_q, duty_eff_nx;
   logic [DEAD_W-1:0] dead_q, dead_nx;
   logic [WDOG_W-1:0] wdog_q, wdog_nx;
   logic             ready_nx, armed_nx, timeout_nx;
   logic             key_meta, key_sync, key_prev;
   logic             key_rise_c, cmd_acc_c, drive_en_c, wrap;

   assign key_rise_c = key_sync & ~key_prev;
   assign cmd_acc_c  = cmd_valid & cmd_ready;
   assign drive_en_c = is_drive(dir_nx);
   assign m1a1       = dir_q[1];
   assign m1b1       = dir_q[0];

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= 1'b0;
         key_sync <= 1'b0;
         key_prev <= 1'b0;
      end else begin
         key_meta <= key;
         key_sync <= key_meta;
         key_prev <= key_sync;
      end
   end

   always_comb begin
      state_nx    = state_q;
      dir_nx      = dir_q;
      pend_nx     = pend_q;
      target_nx   = target_q;
      duty_eff_nx = duty_eff_q;
      dead_nx     = dead_q;
      wdog_nx     = wdog_q;
      armed_nx    = armed;
      timeout_nx  = wdog_timeout;

      // Duty only changes at a period boundary so no runt pulses appear.
      if (wrap) begin
`ifdef MOTOR_RAMP_EN
         if (state_q != ST_DEAD) begin
            if (duty_eff_q < target_q) begin
               duty_eff_nx = duty_eff_q + 1'b1;
            end else if (duty_eff_q > target_q) begin
               duty_eff_nx = duty_eff_q - 1'b1;
            end
         end
`else
         duty_eff_nx = target_q;
`endif
      end

      case (state_q)
         ST_DISARMED: begin
            if (key_rise_c) begin
               state_nx = ST_RUN;
               armed_nx = 1'b1;
               wdog_nx  = WDOG_W'(WDOG_CYCLES);
            end
         end
         ST_RUN: begin
            if (cmd_acc_c) begin
               if (is_reversal(dir_q, cmd_dir)) begin
                  dir_nx       = DIR_COAST;
                  pend_nx.dir  = cmd_dir;
                  pend_nx.duty = cmd_duty;
                  dead_nx      = DEAD_W'(DEAD_CYCLES);
                  state_nx     = ST_DEAD;
`ifdef MOTOR_RAMP_EN
                  duty_eff_nx  = '0;
`endif
               end else begin
                  dir_nx    = cmd_dir;
                  target_nx = cmd_duty;
               end
            end
         end
         ST_DEAD: begin
            if (dead_q == DEAD_W'(1)) begin
               dir_nx    = pend_q.dir;
               target_nx = pend_q.duty;
               dead_nx   = '0;
               state_nx  = ST_RUN;
            end else begin
               dead_nx = dead_q - 1'b1;
            end
         end
         default: state_nx = ST_DISARMED;
      endcase

      // Watchdog: an accept on the expiry cycle reloads and wins over the timeout.
      if (state_q != ST_DISARMED) begin
         if (cmd_acc_c) begin
            wdog_nx    = WDOG_W'(WDOG_CYCLES);
            timeout_nx = 1'b0;
         end else if (wdog_q != '0) begin
            wdog_nx = wdog_q - 1'b1;
            if (wdog_q == WDOG_W'(1)) begin
               dir_nx      = DIR_COAST;
               duty_eff_nx = '0;
               dead_nx     = '0;
               timeout_nx  = 1'b1;
               state_nx    = ST_RUN;
            end
         end
      end

      ready_nx = (state_nx == ST_RUN);
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_DISARMED;
         dir_q        <= DIR_COAST;
         pend_q       <= '0;
         target_q     <= '0;
         duty_eff_q   <= '0;
         dead_q       <= '0;
         wdog_q       <= '0;
         cmd_ready    <= 1'b0;
         armed        <= 1'b0;
         wdog_timeout <= 1'b0;
      end else begin
         state_q      <= state_nx;
         dir_q        <= dir_nx;
         pend_q       <= pend_nx;
         target_q     <= target_nx;
         duty_eff_q   <= duty_eff_nx;
         dead_q       <= dead_nx;
         wdog_q       <= wdog_nx;
         cmd_ready    <= ready_nx;
         armed        <= armed_nx;
         wdog_timeout <= timeout_nx;
      end
   end

   pwm_gen #(
      .PWM_DIV (PWM_DIV)
   ) u_pwm_gen (
      .clk      (clk_50M),
      .rst_n    (rst_n),
      .en       (drive_en_c),
      .duty_eff (duty_eff_q),
      .pwm_out  (pwm_out),
      .wrap     (wrap)
   );

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Scoreboard bench for motor_dir_sequencer: arming, PWM duty, dead-time, brake, watchdog, reset.
module tb_motor_dir_sequencer;

   localparam int unsigned PWM_DIV = 1;
   localparam int unsigned DEAD    = 500;
   localparam int unsigned WDOG    = 1000;

   logic       clk_50M = 1'b0;
   logic       rst_n, key, cmd_valid, cmd_ready;
   logic [1:0] cmd_dir;
   logic [7:0] cmd_duty;
   logic       m1a1, m1b1, pwm_out, armed, wdog_timeout;

   typedef struct {
      logic [1:0]  dir;
      int unsigned dead;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] model_dir;
   int         errors = 0;
   int         checks = 0;

   always #10 clk_50M = ~clk_50M;

   motor_dir_sequencer #(
      .PWM_DIV     (PWM_DIV),
      .DEAD_CYCLES (DEAD),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk_50M      (clk_50M),
      .rst_n        (rst_n),
      .key          (key),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_dir      (cmd_dir),
      .cmd_duty     (cmd_duty),
      .m1a1         (m1a1),
      .m1b1         (m1b1),
      .pwm_out      (pwm_out),
      .armed        (armed),
      .wdog_timeout (wdog_timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50M);
      #1;
   endtask

   // Drive a command and queue what the motor outputs must do once it is accepted.
   task automatic present(input logic [1:0] d, input logic [7:0] du);
      exp_t e;
      cmd_dir   = d;
      cmd_duty  = du;
      cmd_valid = 1'b1;
      e.dir  = d;
      e.dead = ((model_dir == 2'b10 && d == 2'b01) || (model_dir == 2'b01 && d == 2'b10)) ? DEAD : 0;
      exp_q.push_back(e);
      model_dir = d;
   endtask

   task automatic wait_accept(output int waited);
      waited = 0;
      while (!cmd_ready && waited < 3000) begin
         @(negedge clk_50M);
         waited++;
      end
      if (!cmd_ready) check_eq("accept_timeout", 32'(cmd_ready), 1);
      @(posedge clk_50M);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Called one cycle after an accept: pops the expectation and checks the outputs.
   task automatic verify(input string tag);
      exp_t e;
      int   n    = 0;
      int   busy = 0;
      e = exp_q.pop_front();
      if (e.dead != 0) begin
         while ({m1a1, m1b1} == 2'b00 && n < int'(DEAD) + 10) begin
            if (cmd_ready) busy++;
            n++;
            tick();
         end
         check_eq({tag, "_dead"}, n, e.dead);
         check_eq({tag, "_busy"}, busy, 0);
      end
      check_eq({tag, "_dir"}, {m1a1, m1b1}, e.dir);
   endtask

   task automatic send(input logic [1:0] d, input logic [7:0] du, input string tag);
      int w;
      present(d, du);
      wait_accept(w);
      verify(tag);
   endtask

   task automatic count_pwm(input int cycles, output int highs);
      highs = 0;
      repeat (cycles) begin
         @(negedge clk_50M);
         if (pwm_out) highs++;
      end
   endtask

   task automatic arm_key(output int n);
      n   = 0;
      key = 1'b1;
      while (!armed && n < 10) begin
         @(negedge clk_50M);
         n++;
         if (n == 3) key = 1'b0;
      end
      key = 1'b0;
   endtask

   task automatic wait_timeout(output int n);
      n = 0;
      while (!wdog_timeout && n < 2000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, w, viol, highs;
      rst_n = 1'b0; key = 1'b0; cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_duty = 8'd0;
      model_dir = 2'b00;
      repeat (3) tick();
      check_eq("reset_outs", {m1a1, m1b1, pwm_out, cmd_ready, armed, wdog_timeout}, 0);
      @(negedge clk_50M) rst_n = 1'b1;

      // Disarmed: command held, nothing moves.
      cmd_dir = 2'b10; cmd_duty = 8'd128; cmd_valid = 1'b1;
      viol = 0;
      repeat (1000) begin
         @(negedge clk_50M);
         if (cmd_ready || m1a1 || m1b1 || pwm_out || armed || wdog_timeout) viol++;
      end
      check_eq("disarmed_quiet", viol, 0);
      arm_key(n);
      check_eq("armed", 32'(armed), 1);
      check_eq("arm_within_3", 32'(n <= 3), 1);
      send(2'b10, 8'd128, "arm_cmd");

      // PWM duty over one full period.
      send(2'b10, 8'd64, "d64");
      repeat (600) tick();
      count_pwm(256, highs);
      check_eq("pwm_64", highs, 64);
      send(2'b10, 8'd0, "d0");
      repeat (600) tick();
      count_pwm(256, highs);
      check_eq("pwm_0", highs, 0);
      send(2'b10, 8'd255, "d255");
      repeat (600) tick();
      count_pwm(256, highs);
      check_eq("pwm_255", highs, 255);

      // Reversal with a second command held through the dead-time.
      present(2'b01, 8'd100);
      wait_accept(w);
      present(2'b01, 8'd200);
      verify("rev1");
      wait_accept(w);
      check_eq("held_wait", w, 0);
      verify("held");

      // Reversal back, then brake and drive with no dead-time.
      send(2'b10, 8'd128, "rev2");
      send(2'b11, 8'd50, "brake");
      count_pwm(300, highs);
      check_eq("brake_pwm", highs, 0);
      send(2'b01, 8'd50, "brake_to_rev");

      // Watchdog expiry, recovery, and an accept on the expiry cycle.
      wait_timeout(n);
      model_dir = 2'b00;
      check_eq("wd_cycles", n, WDOG);
      check_eq("wd_dir", {m1a1, m1b1}, 0);
      check_eq("wd_pwm", 32'(pwm_out), 0);
      send(2'b10, 8'd80, "wd_clear");
      check_eq("wd_cleared", 32'(wdog_timeout), 0);
      repeat (WDOG - 1) tick();
      send(2'b10, 8'd80, "wd_edge");
      check_eq("wd_edge_to", 32'(wdog_timeout), 0);
      wait_timeout(n);
      model_dir = 2'b00;
      check_eq("wd_reload", n, WDOG);

      // Reset in the middle of dead-time.
      send(2'b10, 8'd200, "pre_rst");
      present(2'b01, 8'd100);
      wait_accept(w);
      exp_q.delete();
      repeat (100) tick();
      check_eq("in_dead", {m1a1, m1b1, cmd_ready}, 0);
      #3 rst_n = 1'b0;
      #1 check_eq("rst_dead", {m1a1, m1b1, pwm_out, cmd_ready, armed, wdog_timeout}, 0);
      model_dir = 2'b00;
      @(negedge clk_50M) rst_n = 1'b1;
      arm_key(n);
      check_eq("rearm", 32'(armed), 1);

      // Reset during a PWM high phase.
      send(2'b10, 8'd255, "rst_pwm_cmd");
      n = 0;
      while (!pwm_out && n < 600) begin
         @(negedge clk_50M);
         n++;
      end
      check_eq("pwm_high", 32'(pwm_out), 1);
      #3 rst_n = 1'b0;
      #1 check_eq("rst_pwm", {m1a1, m1b1, pwm_out, cmd_ready, armed, wdog_timeout}, 0);
      model_dir = 2'b00;
      @(negedge clk_50M) rst_n = 1'b1;
      cmd_dir = 2'b10; cmd_duty = 8'd10; cmd_valid = 1'b1;
      repeat (20) @(negedge clk_50M);
      check_eq("post_rst_disarmed", {armed, cmd_ready, m1a1, m1b1}, 0);
      arm_key(n);
      check_eq("post_rst_rearm", 32'(armed), 1);
      cmd_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
